// File: rtl/loba_pkg.sv
// Shared definitions for the sequential LOBA multiplier:
// FSM encoding and width helpers.
package loba_pkg;

    localparam int N_DEF = 16;
    localparam int K_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXT_A = 3'd1,
        EXT_B = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int prod_w(int n);
        return 2 * n;
    endfunction

    function automatic int exp_w(int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/loba_mult_seq_if.sv
// Operand/result valid-ready bundle between the operand source,
// the LOBA multiplier and the result consumer.
interface loba_mult_seq_if #(
    parameter int N = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/loba_xh.sv
// Leading-one extractor: position k of the leading one and the
// K bits from it downward (low bits of x when k < K-1).
module loba_xh
    import loba_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic [N-1:0]          x,
    output logic [K-1:0]          xh,
    output logic [exp_w(N)-1:0]   k
);
    localparam int EW = exp_w(N);
    localparam logic [EW-1:0] KM1 = EW'(K - 1);

    logic [EW-1:0] sh;

    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) k = EW'(i);
        end
    end

    assign sh = (k >= KM1) ? k - KM1 : '0;
    assign xh = K'(x >> sh);

endmodule

// File: rtl/loba_mult_seq.sv
// Sequential LOBA multiplier: one shared extractor, walked over
// a then b, followed by a single multiply-and-shift step.
module loba_mult_seq
    import loba_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    loba_mult_seq_if.slave  bus,
    output logic            busy
);
    localparam int PW = prod_w(N);
    localparam int EW = exp_w(N);
    localparam logic [EW-1:0] KM1 = EW'(K - 1);

    state_t state;
    state_t state_nxt;

    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   x_sel;
    logic [K-1:0]   xh;
    logic [EW-1:0]  k;
    logic [K-1:0]   xh_a;
    logic [K-1:0]   xh_b;
    logic [EW-1:0]  e_a;
    logic [EW-1:0]  e_b;
    logic [EW:0]    esum;
    logic [2*K-1:0] m;
    logic [PW-1:0]  p_r;
    logic           accept;
    logic           zero_in;

    assign accept  = bus.in_valid && (state == IDLE);
    assign zero_in = (bus.a == '0) || (bus.b == '0);

    // Extractor sees only registered operands, never the live inputs
    assign x_sel = (state == EXT_B) ? b_r : a_r;

    loba_xh #(
        .N (N),
        .K (K)
    ) u_xh (
        .x  (x_sel),
        .xh (xh),
        .k  (k)
    );

    assign esum = {1'b0, e_a} + {1'b0, e_b};
    assign m    = {{K{1'b0}}, xh_a} * {{K{1'b0}}, xh_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = zero_in ? DONE : EXT_A;
            EXT_A:   state_nxt = EXT_B;
            EXT_B:   state_nxt = CALC;
            CALC:    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            xh_a <= '0;
            xh_b <= '0;
            e_a  <= '0;
            e_b  <= '0;
            p_r  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                        if (zero_in) p_r <= '0;
                    end
                end
                EXT_A: begin
                    if (k < KM1) begin
                        xh_a <= a_r[K-1:0];
                        e_a  <= '0;
                    end else begin
                        xh_a <= xh;
                        e_a  <= k - KM1;
                    end
                end
                EXT_B: begin
                    if (k < KM1) begin
                        xh_b <= b_r[K-1:0];
                        e_b  <= '0;
                    end else begin
                        xh_b <= xh;
                        e_b  <= k - KM1;
                    end
                end
                CALC:    p_r <= PW'(m) << esum;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p         = p_r;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_loba_mult_seq.sv
// Directed + random bench for loba_mult_seq with a result scoreboard.
module tb_loba_mult_seq;

    logic clk;
    logic rst_n;
    logic busy;

    loba_mult_seq_if #(.N(16)) bus ();

    loba_mult_seq #(.N(16), .K(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [31:0] sb_q[$];
    time t_acc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void approx(input logic [15:0] x,
                                   output logic [31:0] xh,
                                   output int e);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) if (x[i]) k = i;
        if (k < 3) begin
            xh = {16'd0, x};
            e  = 0;
        end else begin
            xh = ({16'd0, x} >> (k - 3)) & 32'hF;
            e  = k - 3;
        end
    endfunction

    function automatic logic [31:0] ref_p(input logic [15:0] x,
                                          input logic [15:0] y);
        logic [31:0] hx, hy;
        int ex, ey;
        if (x == 0 || y == 0) return 32'd0;
        approx(x, hx, ex);
        approx(y, hy, ey);
        return (hx * hy) << (ex + ey);
    endfunction

    task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                        input logic [31:0] exp, input bit push);
        bit got;
        got = 0;
        bus.a = xa;
        bus.b = xb;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("send_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        if (push) sb_q.push_back(exp);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input int lat, input int hold);
        int n;
        logic [31:0] exp;
        bus.out_ready = (hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            bus.out_ready = 1'b1;
            return;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd1, 32'd0);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        chk({tag, "_p"}, bus.p, exp);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, "_hold_p"}, bus.p, exp);
            chk({tag, "_hold_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra, rb;
        time t_prev;
        bit prev_zero;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_p", bus.p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(16'h00F0, 16'h0003, 32'h0000_02D0, 1);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        get("f0x3", 4, 0);

        send(16'hFFFF, 16'hFFFF, 32'hE100_0000, 1);
        get("max", 4, 0);

        send(16'h1234, 16'h0010, 32'h0001_2000, 1);
        get("mixed_bp", 4, 3);

        // Abort an operation while it sits in EXT_B
        send(16'h1111, 16'h2222, 32'd0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_p", bus.p, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h00F0, 16'h0003, 32'h0000_02D0, 1);
        get("after_rst", 4, 0);

        send(16'h0000, 16'h1234, 32'd0, 1);
        bus.a = 16'h5555;
        bus.b = 16'h7777;
        bus.in_valid = 1'b1;
        get("zero_busy", 1, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_extra_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        t_prev = 0;
        prev_zero = 0;
        for (int i = 0; i < 100; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 16'd0
                 : 16'($urandom >> $urandom_range(0, 31));
            rb = ($urandom_range(0, 9) == 0) ? 16'd0
                 : 16'($urandom >> $urandom_range(0, 31));
            send(ra, rb, ref_p(ra, rb), 1);
            if (i > 0)
                chk("rand_spacing", 32'((t_acc - t_prev) / 10),
                    prev_zero ? 32'd2 : 32'd5);
            t_prev = t_acc;
            prev_zero = (ra == 0) || (rb == 0);
            get("rand", prev_zero ? 1 : 4, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/loba_mult_seq.md
Name: loba_mult_seq

Overview:
- Sequential leading-one-based approximate (LOBA) multiplier controller.
- Time-shares one leading-one extractor (loba_xh) between both operands.
- Sequences extraction, product and shift, and hands the result downstream over valid/ready.
- Sits between an operand source and the result consumer in the approximate-arithmetic datapath.

Parameters:
N, 16, operand width in bits; product width is 2N.
K, 4, bits kept from the leading one downward (K <= N).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair a/b valid.
in_ready  output  1  block can accept operands.
a  input  N  operand A, unsigned.
b  input  N  operand B, unsigned.
out_valid  output  1  p valid.
out_ready  input  1  consumer accepts p.
p  output  2N  approximate product, unsigned.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asynchronous, any state: state=IDLE; in_ready=1, out_valid=0, busy=0, p=0; all internal registers cleared. A mid-operation reset discards the operation; no output is produced.
- States: IDLE, EXT_A, EXT_B, CALC, DONE. Encoding is in the package.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a and b into a_r and b_r.
  - If a==0 or b==0: p<=0 and go to DONE (latency 1 clock).
  - Otherwise go to EXT_A.
- EXT_A:
  - Extractor input mux selects a_r.
  - Register xh_a and k_a.
  - If k_a < K-1: xh_a=a_r[K-1:0], e_a=0 (exact, avoids index underflow).
  - Else: xh_a=extractor xh, e_a=k_a-(K-1).
  - Go to EXT_B.
- EXT_B: same as EXT_A on b_r, producing xh_b and e_b. Go to CALC.
- CALC:
  - p <= (xh_a*xh_b) << (e_a+e_b).
  - xh_a*xh_b is 2K bits; the shift amount is at most 2(N-K); the result always fits in 2N bits with no truncation.
  - Go to DONE.
- DONE:
  - out_valid=1; p is held stable while out_ready=0.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready stays 0 throughout; no overlap of operations.
- Latency: out_valid rises 4 clocks after the accepting edge for nonzero operands, 1 clock after for a zero operand.
- Throughput: one result per 5 clocks, given out_ready=1.
- The extractor is purely combinational. Its input is driven from a registered mux selected only by state, so there is no path from a/b to p.
- in_valid asserted outside IDLE is ignored. a and b are sampled only at the handshake.
- busy = (state != IDLE).

Decomposition:
- Package loba_pkg:
  - state encoding constants: IDLE=0, EXT_A=1, EXT_B=2, CALC=3, DONE=4 (3 bits).
  - localparam helpers: product width 2N; exponent width clog2(N)+1.
- Sub-module: one loba_xh instance (N, K passed through) as the shared extractor.
- Everything else lives in loba_mult_seq.

Test Plan:
- Reset mid-operation: assert rst_n=0 during EXT_B → immediately in_ready=1, out_valid=0, p=0; the next operation completes normally.
- Normal operation, approximated A and exact B: a=0x00F0, b=0x0003 → xh_a=15, e_a=4; b exact (xh_b=3, e_b=0); p=0x000002D0; out_valid 4 clocks after accept.
- Maximum operands: a=0xFFFF, b=0xFFFF → xh=15, e=12 each; p=0xE1000000 (approximation of 0xFFFE0001).
- Mixed operands with backpressure: a=0x1234, b=0x0010 → xh_a=9, e_a=9; xh_b=8, e_b=1; p=0x00012000. Hold out_ready=0 for 3 clocks → p stable and out_valid held; in_ready=0 until the output handshake.
- Zero operand and busy input: a=0x0000, b=0x1234 → p=0, out_valid 1 clock after accept. Pulse in_valid during busy with different operands → ignored, no extra result.
- Back-to-back: 100 random pairs with out_ready=1 → each p equals the reference model; one result per 5 clocks; zero pairs take 2 clocks.
